// File: rtl/pid_pkg.sv
// Shared types and constants for the time-multiplexed PID scheduler.
// No ports: imported by pid_term_calc and pid_axis_scheduler.
package pid_pkg;

  typedef logic signed [15:0] q88_t;

  typedef enum logic [1:0] {
    KP,
    KI,
    KD,
    CLR
  } gain_sel_e;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC
  } sched_state_e;

  localparam q88_t INT_MAX = 16'sh7FFF;
  localparam q88_t INT_MIN = 16'sh8000;

endpackage

// File: rtl/pid_term_calc.sv
// Combinational PID arithmetic for one axis (Q8.8 in, Q8.8 out).
// Ports: e, last_error, integral, kp, ki, kd -> out, next_integral.
module pid_term_calc (
  input  logic signed [15:0] e,
  input  logic signed [15:0] last_error,
  input  logic signed [15:0] integral,
  input  logic signed [15:0] kp,
  input  logic signed [15:0] ki,
  input  logic signed [15:0] kd,
  output logic signed [15:0] out,
  output logic signed [15:0] next_integral
);
  import pid_pkg::*;

  logic signed [16:0] w_diff;
  logic signed [31:0] w_p_prod;
  logic signed [31:0] w_i_prod;
  logic signed [31:0] w_d_prod;
  logic signed [15:0] w_p;
  logic signed [15:0] w_i;
  logic signed [15:0] w_d;
  logic signed [17:0] w_total;
  logic signed [16:0] w_isum;
  logic               w_unused;

  assign w_diff   = 17'(e) - 17'(last_error);
  assign w_p_prod = 32'(kp) * 32'(e);
  assign w_i_prod = 32'(ki) * 32'(integral);
  assign w_d_prod = 32'(kd) * 32'(w_diff);

  // >>>8 then truncate to 16 bits == product bits [23:8]
  assign w_p = w_p_prod[23:8];
  assign w_i = w_i_prod[23:8];
  assign w_d = w_d_prod[23:8];

  assign w_total = 18'(w_p) + 18'(w_i) + 18'(w_d);
  assign out     = w_total[17:2];

  // 17-bit sum overflows 16 bits when its top two bits differ
  assign w_isum = 17'(e) + 17'(integral);
  assign next_integral =
    (w_isum[16] != w_isum[15]) ?
      (w_isum[16] ? INT_MIN : INT_MAX) :
      w_isum[15:0];

  assign w_unused = ^{w_p_prod[31:24], w_p_prod[7:0],
                      w_i_prod[31:24], w_i_prod[7:0],
                      w_d_prod[31:24], w_d_prod[7:0],
                      w_total[1:0]};

endmodule

// File: rtl/pid_axis_scheduler.sv
// Shares one PID datapath across NUM_AXES axes, one result per 2 cycles.
// Ports: tick/enable, packed errors, gain config port, result strobe, status.
module pid_axis_scheduler #(
  parameter  int NUM_AXES = 4,
  localparam int AXIS_W   = $clog2(NUM_AXES)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_tick,
  input  logic                    pid_en,
  input  logic [16*NUM_AXES-1:0]  err_in,
  input  logic                    cfg_we,
  input  logic [AXIS_W-1:0]       cfg_axis,
  input  logic [1:0]              cfg_sel,
  input  logic [15:0]             cfg_data,
  input  logic                    ovr_clr,
  output logic [15:0]             out_data,
  output logic [AXIS_W-1:0]       out_axis,
  output logic                    out_valid,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    overrun
);
  import pid_pkg::*;

  sched_state_e      r_state;
  logic [AXIS_W-1:0] r_axis;

  q88_t r_snap [NUM_AXES];
  q88_t r_kp   [NUM_AXES];
  q88_t r_ki   [NUM_AXES];
  q88_t r_kd   [NUM_AXES];
  q88_t r_int  [NUM_AXES];
  q88_t r_last [NUM_AXES];

  q88_t r_e;
  q88_t r_skp;
  q88_t r_ski;
  q88_t r_skd;
  q88_t r_sint;
  q88_t r_slast;

  q88_t w_out;
  q88_t w_next_int;
  logic w_cfg_ok;
  logic w_last_axis;

  assign w_cfg_ok =
    {1'b0, cfg_axis} < (AXIS_W+1)'(NUM_AXES);
  assign w_last_axis =
    (r_axis == AXIS_W'(NUM_AXES - 1));

  pid_term_calc u_calc (
    .e             (r_e),
    .last_error    (r_slast),
    .integral      (r_sint),
    .kp            (r_skp),
    .ki            (r_ski),
    .kd            (r_skd),
    .out           (w_out),
    .next_integral (w_next_int)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_axis     <= '0;
      out_data   <= '0;
      out_axis   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      r_e        <= '0;
      r_skp      <= '0;
      r_ski      <= '0;
      r_skd      <= '0;
      r_sint     <= '0;
      r_slast    <= '0;
      for (int k = 0; k < NUM_AXES; k++) begin
        r_snap[k] <= '0;
        r_kp[k]   <= '0;
        r_ki[k]   <= '0;
        r_kd[k]   <= '0;
        r_int[k]  <= '0;
        r_last[k] <= '0;
      end
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (ovr_clr) overrun <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (sample_tick && pid_en) begin
            for (int k = 0; k < NUM_AXES; k++)
              r_snap[k] <= err_in[16*k +: 16];
            r_axis  <= '0;
            busy    <= 1'b1;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          if (sample_tick) overrun <= 1'b1;
          r_e     <= r_snap[r_axis];
          r_skp   <= r_kp[r_axis];
          r_ski   <= r_ki[r_axis];
          r_skd   <= r_kd[r_axis];
          r_sint  <= r_int[r_axis];
          r_slast <= r_last[r_axis];
          r_state <= EXEC;
        end
        EXEC: begin
          if (sample_tick) overrun <= 1'b1;
          out_data       <= w_out;
          out_axis       <= r_axis;
          out_valid      <= 1'b1;
          r_int[r_axis]  <= w_next_int;
          r_last[r_axis] <= r_e;
          if (w_last_axis) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_axis  <= r_axis + AXIS_W'(1);
            r_state <= FETCH;
          end
        end
        default: r_state <= IDLE;
      endcase

      // After the write-back so a clear of the same axis wins
      if (cfg_we && w_cfg_ok) begin
        unique case (gain_sel_e'(cfg_sel))
          KP:  r_kp[cfg_axis] <= cfg_data;
          KI:  r_ki[cfg_axis] <= cfg_data;
          KD:  r_kd[cfg_axis] <= cfg_data;
          CLR: begin
            r_int[cfg_axis]  <= '0;
            r_last[cfg_axis] <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pid_axis_scheduler.sv
// Bench for pid_axis_scheduler: frame-level model plus directed literals.
// No ports.
module tb_pid_axis_scheduler;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sample_tick = 1'b0;
  logic          pid_en = 1'b0;
  logic [16*N-1:0] err_in = '0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_axis = '0;
  logic [1:0]    cfg_sel = '0;
  logic [15:0]   cfg_data = '0;
  logic          ovr_clr = 1'b0;
  logic [15:0]   out_data;
  logic [1:0]    out_axis;
  logic          out_valid;
  logic          frame_done;
  logic          busy;
  logic          overrun;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  pid_axis_scheduler #(.NUM_AXES(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .pid_en      (pid_en),
    .err_in      (err_in),
    .cfg_we      (cfg_we),
    .cfg_axis    (cfg_axis),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .ovr_clr     (ovr_clr),
    .out_data    (out_data),
    .out_axis    (out_axis),
    .out_valid   (out_valid),
    .frame_done  (frame_done),
    .busy        (busy),
    .overrun     (overrun)
  );

  typedef struct {
    int cyc;
    int ax;
    int data;
    bit last;
  } exp_t;

  exp_t q[$];
  int m_kp[N];
  int m_ki[N];
  int m_kd[N];
  int m_int[N];
  int m_last[N];
  int m_snap[N];
  int seen[N];
  bit m_active = 0;
  bit m_ovr = 0;
  bit m_wb = 0;
  int m_start = 0;
  int m_wb_ax = 0;
  int m_wb_int = 0;
  int m_wb_last = 0;

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d want %0d",
               nm, cyc, act, exp);
    end
  endtask

  function automatic int t16(int v);
    logic [15:0] b;
    b = v[15:0];
    return int'($signed(b));
  endfunction

  function automatic int sat16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int pid_out(int e, int lst, int ig,
                                 int kp, int ki, int kd);
    int p, i, d;
    p = t16((kp * e) >>> 8);
    i = t16((ki * ig) >>> 8);
    d = t16((kd * (e - lst)) >>> 8);
    return (p + i + d) >>> 2;
  endfunction

  // Frame model: axis k is fetched on edge start+1+2k and
  // reported / written back on the next edge.
  always @(posedge clk or negedge reset_n) begin
    int rel, k;
    if (!reset_n) begin
      for (int a = 0; a < N; a++) begin
        m_kp[a] = 0; m_ki[a] = 0; m_kd[a] = 0;
        m_int[a] = 0; m_last[a] = 0;
      end
      m_active = 0;
      m_ovr = 0;
      m_wb = 0;
      q.delete();
    end else begin
      cyc++;
      if (m_wb) begin
        m_int[m_wb_ax] = m_wb_int;
        m_last[m_wb_ax] = m_wb_last;
        m_wb = 0;
      end
      rel = cyc - m_start;
      if (m_active && rel >= 1 && rel <= 2*N && rel % 2 == 1) begin
        k = (rel - 1) / 2;
        q.push_back('{cyc + 1, k,
          pid_out(m_snap[k], m_last[k], m_int[k],
                  m_kp[k], m_ki[k], m_kd[k]),
          (k == N - 1)});
        m_wb = 1;
        m_wb_ax = k;
        m_wb_int = sat16(m_snap[k] + m_int[k]);
        m_wb_last = m_snap[k];
      end
      if (ovr_clr) m_ovr = 0;
      if (sample_tick) begin
        if (m_active && rel >= 1 && rel <= 2*N) m_ovr = 1;
        else if (pid_en) begin
          m_active = 1;
          m_start = cyc;
          for (int a = 0; a < N; a++)
            m_snap[a] = int'($signed(err_in[16*a +: 16]));
        end
      end
      if (cfg_we) begin
        case (cfg_sel)
          2'd0: m_kp[cfg_axis] = int'($signed(cfg_data));
          2'd1: m_ki[cfg_axis] = int'($signed(cfg_data));
          2'd2: m_kd[cfg_axis] = int'($signed(cfg_data));
          default: begin
            m_int[cfg_axis] = 0;
            m_last[cfg_axis] = 0;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    ev = (q.size() > 0 && q[0].cyc == cyc);
    chk("out_valid", int'(out_valid), int'(ev));
    if (ev) begin
      chk("out_data", int'($signed(out_data)), q[0].data);
      chk("out_axis", int'(out_axis), q[0].ax);
      chk("frame_done", int'(frame_done), int'(q[0].last));
      seen[q[0].ax] = int'($signed(out_data));
      void'(q.pop_front());
    end else begin
      chk("frame_done_idle", int'(frame_done), 0);
    end
    chk("busy", int'(busy),
        int'(m_active && cyc >= m_start && cyc <= m_start + 2*N - 1));
    chk("overrun", int'(overrun), int'(m_ovr));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(int ax, int sel, int d);
    cfg_we = 1'b1;
    cfg_axis = 2'(ax);
    cfg_sel = 2'(sel);
    cfg_data = 16'(d);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic set_err(int e0, int e1, int e2, int e3);
    err_in = {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic frame();
    tick();
    repeat (2*N + 1) step();
  endtask

  initial begin
    int exp0[N];
    repeat (3) step();
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    step();

    // proportional only
    pid_en = 1'b1;
    cfg(0, 0, 'h0100);
    set_err(400, 0, 0, 0);
    frame();
    exp0 = '{100, 0, 0, 0};
    for (int k = 0; k < N; k++) chk("p_only", seen[k], exp0[k]);

    // tick with pid_en low is ignored
    pid_en = 1'b0;
    tick();
    repeat (2*N + 1) step();
    pid_en = 1'b1;

    // derivative
    cfg(1, 2, 'h0100);
    set_err(0, 100, 0, 0);
    frame();
    chk("d_frame1", seen[1], 25);
    set_err(0, 300, 0, 0);
    frame();
    chk("d_frame2", seen[1], 50);

    // integral saturation
    set_err(0, 300, 'h7000, 0);
    repeat (3) frame();
    cfg(2, 1, 'h0100);
    frame();
    chk("i_sat", seen[2], 8191);
    cfg(2, 1, 0);

    // overrun
    tick();
    repeat (3) step();
    tick();
    repeat (2*N - 3) step();
    chk("ovr_set", int'(overrun), 1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("ovr_clr", int'(overrun), 0);
    tick();
    repeat (3) step();
    sample_tick = 1'b1;
    ovr_clr = 1'b1;
    step();
    sample_tick = 1'b0;
    ovr_clr = 1'b0;
    chk("ovr_set_wins", int'(overrun), 1);
    repeat (2*N - 3) step();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;

    // config collisions
    cfg(1, 1, 'h0100);
    set_err(0, 300, 'h0100, 0);
    tick();
    repeat (3) step();
    cfg(1, 3, 0);
    cfg(2, 0, 'h0200);
    repeat (4) step();
    chk("kp_old", seen[2], 0);
    frame();
    chk("kp_new", seen[2], 128);
    chk("clr_wins", seen[1], 75);

    // reset mid-frame
    tick();
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_done", int'(frame_done), 0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    set_err(100, 200, 300, 400);
    for (int k = 0; k < N; k++) seen[k] = -1;
    frame();
    for (int k = 0; k < N; k++) chk("post_rst", seen[k], 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
